uart_rx_ctrl: RTL and testbench

UART receive controller. It deserializes 8-bit asynchronous frames from the `uart_rx` pin using the same baud and parity parameterization as the UART transmit controller. Received bytes are buffered in a small internal FIFO and presented to the system side on a valid/ready interface. It sits between the board UART pin and the command/data-path logic, and forms the receive half of the UART pair.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
// FSM encoding, baud shift helper and parity-type names.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam string PAR_NONE = "no parity";
    localparam string PAR_ODD  = "odd parity";
    localparam string PAR_EVEN = "even parity";

    // Clocks per bit: the base divider scaled up for slow rates.
    function automatic logic [15:0] bit_cycles(
        input int          baud,
        input logic [15:0] div
    );
        case (baud)
            2400:    return div << 4;
            4800:    return div << 3;
            9600:    return div << 2;
            19200:   return div << 1;
            38400:   return div;
            115200:  return div;
            default: return div << 2;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO.
// A pop frees a full slot for a push in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rd_en;
    logic             wr_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Storage array; contents only matter behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with FWFT output buffer.
// Samples mid-bit after a half-bit start qualification.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          BAUDRATE    = 115200,
    parameter logic [15:0] CLK_DIV     = 16'd868,
    parameter string       PARITY_TYPE = "no parity",
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overflow
);

    localparam logic [15:0] BIT_CYC = bit_cycles(BAUDRATE, CLK_DIV);
    localparam logic [15:0] HALF    = BIT_CYC >> 1;
    localparam bit PAR_IS_ODD  = (PARITY_TYPE == PAR_ODD);
    localparam bit PAR_IS_EVEN = (PARITY_TYPE == PAR_EVEN);
    localparam bit PAR_EN      = PAR_IS_ODD | PAR_IS_EVEN;

    logic        rx_meta;
    logic        rxd_s;
    logic        rxd_d;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_bad;
    logic        push_q;
    logic        fe_q;
    logic        pe_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        half_tick;
    logic        bit_tick;
    logic        par_x;

    assign half_tick = (cnt == HALF - 16'd1);
    assign bit_tick  = (cnt == BIT_CYC - 16'd1);
    assign par_x     = (^shreg) ^ rxd_s;

    // Two-flop synchronizer plus one delay stage for edge detect.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_meta <= 1'b1;
            rxd_s   <= 1'b1;
            rxd_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxd_s   <= rx_meta;
            rxd_d   <= rxd_s;
        end
    end

    // Frame FSM, baud counter, shift register and result strobes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            push_q  <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            fe_q   <= 1'b0;
            pe_q   <= 1'b0;
            cnt    <= cnt + 16'd1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rxd_d & ~rxd_s) state <= ST_START;
                end
                ST_START: begin
                    if (half_tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        state   <= rxd_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bad <= PAR_IS_ODD ? ~par_x : par_x;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!rxd_s)       fe_q   <= 1'b1;
                        else if (par_bad) pe_q   <= 1'b1;
                        else              push_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push_q),
        .pop   (rx_ready),
        .din   (shreg),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid   = ~fifo_empty;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overflow   = push_q & fifo_full & ~rx_ready;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl.
// Three receivers: no parity, even parity, odd parity.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] line = 3'b111;
    logic [2:0] ready = 3'b111;
    wire  [7:0] d0, d1, d2;
    wire  [2:0] vld, fe, pe, ov;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int pops [3] = '{0, 0, 0};
    int fes  [3] = '{0, 0, 0};
    int pes  [3] = '{0, 0, 0};
    int ovs  [3] = '{0, 0, 0};
    logic [7:0] last [3] = '{8'h0, 8'h0, 8'h0};
    int   rise0 = -1;
    logic pv0 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.BAUDRATE(38400), .CLK_DIV(16'd16),
        .PARITY_TYPE("no parity"), .FIFO_DEPTH(16)) u0 (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(line[0]),
        .rx_data(d0), .rx_valid(vld[0]), .rx_ready(ready[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overflow(ov[0]));

    uart_rx_ctrl #(.BAUDRATE(38400), .CLK_DIV(16'd16),
        .PARITY_TYPE("even parity"), .FIFO_DEPTH(16)) u1 (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(line[1]),
        .rx_data(d1), .rx_valid(vld[1]), .rx_ready(ready[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overflow(ov[1]));

    uart_rx_ctrl #(.BAUDRATE(38400), .CLK_DIV(16'd16),
        .PARITY_TYPE("odd parity"), .FIFO_DEPTH(16)) u2 (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(line[2]),
        .rx_data(d2), .rx_valid(vld[2]), .rx_ready(ready[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overflow(ov[2]));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && ready[i]) pops[i] <= pops[i] + 1;
            if (fe[i]) fes[i] <= fes[i] + 1;
            if (pe[i]) pes[i] <= pes[i] + 1;
            if (ov[i]) ovs[i] <= ovs[i] + 1;
        end
        if (vld[0] && ready[0]) last[0] <= d0;
        if (vld[1] && ready[1]) last[1] <= d1;
        if (vld[2] && ready[2]) last[2] <= d2;
    end

    always @(negedge clk) begin
        if (vld[0] && !pv0) rise0 <= cyc;
        pv0 <= vld[0];
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int i, input logic [7:0] b,
                              input bit par_en, input logic par_b,
                              input logic stop_b);
        line[i] = 1'b0;
        tick(16);
        for (int k = 0; k < 8; k++) begin
            line[i] = b[k];
            tick(16);
        end
        if (par_en) begin
            line[i] = par_b;
            tick(16);
        end
        line[i] = stop_b;
        tick(16);
    endtask

    task automatic test_reset();
        tick(3);
        nchk++;
        if ({d0, d1, d2} !== 24'h0) begin
            nerr++;
            $display("FAIL rst_data: got %h expected 0", {d0, d1, d2});
        end
        nchk++;
        if ({vld, fe, pe, ov} !== 12'h0) begin
            nerr++;
            $display("FAIL rst_flags: got %h expected 0", {vld, fe, pe, ov});
        end
        nchk++;
        if (u0.state !== ST_IDLE) begin
            nerr++;
            $display("FAIL rst_state: got %0d expected %0d", u0.state, ST_IDLE);
        end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_byte_55();
        int p, f, e, k;
        p = pops[0]; f = fes[0]; e = pes[0];
        k = cyc;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        tick(4);
        nchk++;
        if (rise0 !== k + 156) begin
            nerr++;
            $display("FAIL b55_rise: got %0d expected %0d", rise0, k + 156);
        end
        nchk++;
        if (pops[0] - p !== 1) begin
            nerr++;
            $display("FAIL b55_pops: got %0d expected 1", pops[0] - p);
        end
        nchk++;
        if (last[0] !== 8'h55) begin
            nerr++;
            $display("FAIL b55_data: got %h expected 55", last[0]);
        end
        nchk++;
        if (fes[0] - f + pes[0] - e !== 0) begin
            nerr++;
            $display("FAIL b55_err: got %0d expected 0", fes[0] - f + pes[0] - e);
        end
        nchk++;
        if (vld[0] !== 1'b0) begin
            nerr++;
            $display("FAIL b55_vld: got %b expected 0", vld[0]);
        end
    endtask

    task automatic test_glitch();
        int p, f;
        p = pops[0]; f = fes[0];
        line[0] = 1'b0;
        tick(5);
        line[0] = 1'b1;
        tick(40);
        nchk++;
        if (u0.state !== ST_IDLE) begin
            nerr++;
            $display("FAIL gl_state: got %0d expected %0d", u0.state, ST_IDLE);
        end
        nchk++;
        if ((pops[0] - p) + (fes[0] - f) !== 0 || vld[0] !== 1'b0) begin
            nerr++;
            $display("FAIL gl_act: got pops %0d fe %0d vld %b expected 0",
                     pops[0] - p, fes[0] - f, vld[0]);
        end
    endtask

    task automatic test_frame_err();
        int p, f;
        p = pops[0]; f = fes[0];
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
        tick(40);
        nchk++;
        if (fes[0] - f !== 1) begin
            nerr++;
            $display("FAIL fe_cnt: got %0d expected 1", fes[0] - f);
        end
        nchk++;
        if (vld[0] !== 1'b0 || pops[0] - p !== 0) begin
            nerr++;
            $display("FAIL fe_push: got vld %b pops %0d expected 0",
                     vld[0], pops[0] - p);
        end
        line[0] = 1'b1;
        tick(20);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        tick(4);
        nchk++;
        if (last[0] !== 8'h3C || pops[0] - p !== 1) begin
            nerr++;
            $display("FAIL fe_next: got %h/%0d expected 3c/1",
                     last[0], pops[0] - p);
        end
        nchk++;
        if (fes[0] - f !== 1) begin
            nerr++;
            $display("FAIL fe_total: got %0d expected 1", fes[0] - f);
        end
    endtask

    task automatic test_parity();
        int p, e;
        p = pops[1]; e = pes[1];
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        tick(4);
        nchk++;
        if (last[1] !== 8'h07 || pops[1] - p !== 1 || pes[1] !== e) begin
            nerr++;
            $display("FAIL even_ok: got %h/%0d/%0d expected 07/1/0",
                     last[1], pops[1] - p, pes[1] - e);
        end
        p = pops[1];
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        tick(4);
        nchk++;
        if (pes[1] - e !== 1 || pops[1] - p !== 0) begin
            nerr++;
            $display("FAIL even_bad: got pe %0d pops %0d expected 1/0",
                     pes[1] - e, pops[1] - p);
        end
        p = pops[2]; e = pes[2];
        send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
        tick(4);
        nchk++;
        if (last[2] !== 8'h07 || pops[2] - p !== 1 || pes[2] !== e) begin
            nerr++;
            $display("FAIL odd_ok: got %h/%0d/%0d expected 07/1/0",
                     last[2], pops[2] - p, pes[2] - e);
        end
        p = pops[2];
        send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
        tick(4);
        nchk++;
        if (pes[2] - e !== 1 || pops[2] - p !== 0) begin
            nerr++;
            $display("FAIL odd_bad: got pe %0d pops %0d expected 1/0",
                     pes[2] - e, pops[2] - p);
        end
    endtask

    task automatic test_overflow();
        int o;
        logic [7:0] b;
        ready[0] = 1'b0;
        o = ovs[0];
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            send_frame(0, b, 1'b0, 1'b0, 1'b1);
            tick(2);
        end
        nchk++;
        if (ovs[0] - o !== 0 || vld[0] !== 1'b1 || d0 !== 8'h00) begin
            nerr++;
            $display("FAIL ov_fill: got ov %0d vld %b d %h expected 0/1/00",
                     ovs[0] - o, vld[0], d0);
        end
        send_frame(0, 8'h10, 1'b0, 1'b0, 1'b1);
        tick(4);
        nchk++;
        if (ovs[0] - o !== 1) begin
            nerr++;
            $display("FAIL ov_pulse: got %0d expected 1", ovs[0] - o);
        end
        ready[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            nchk++;
            if (vld[0] !== 1'b1 || d0 !== b) begin
                nerr++;
                $display("FAIL ov_drain%0d: got vld %b d %h expected 1/%h",
                         i, vld[0], d0, b);
            end
            tick(1);
        end
        nchk++;
        if (vld[0] !== 1'b0) begin
            nerr++;
            $display("FAIL ov_empty: got %b expected 0", vld[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int p;
        ready[0] = 1'b1;
        p = pops[0];
        line[0] = 1'b0;
        tick(16);
        line[0] = 1'b1;
        tick(64 + 8);
        rst = 1'b1;
        tick(2);
        nchk++;
        if (d0 !== 8'h0 || {vld, fe, pe, ov} !== 12'h0) begin
            nerr++;
            $display("FAIL mr_out: got %h %h expected 0", d0, {vld, fe, pe, ov});
        end
        nchk++;
        if (u0.state !== ST_IDLE || u0.cnt !== 16'd0) begin
            nerr++;
            $display("FAIL mr_state: got %0d/%0d expected %0d/0",
                     u0.state, u0.cnt, ST_IDLE);
        end
        rst = 1'b0;
        tick(200);
        nchk++;
        if (pops[0] - p !== 0) begin
            nerr++;
            $display("FAIL mr_push: got %0d expected 0", pops[0] - p);
        end
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        tick(4);
        nchk++;
        if (last[0] !== 8'h81 || pops[0] - p !== 1) begin
            nerr++;
            $display("FAIL mr_next: got %h/%0d expected 81/1",
                     last[0], pops[0] - p);
        end
    endtask

    initial begin
        test_reset();
        test_byte_55();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
